// File: rtl/sincos_sched.sv
// sincos_sched: sequencing controller and two-port round-robin arbiter in front of a
// shared combinational sin/cos unit. The unit is treated as a SETTLE-cycle multicycle
// path: dp_in/dp_sel are held stable for SETTLE cycles per function and dp_result is
// registered on the last one.
//
// Optional feature: define SINCOS_SCHED_SPECIAL_BYPASS_EN to return quiet NaN directly
// for Inf/NaN angles (exponent all ones), skipping the datapath.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req0_* / req1_*             valid/ready angle requests; mode bit0 = sin, bit1 = cos
//   rsp_valid/rsp_ready         shared response handshake
//   rsp_id, rsp_sin, rsp_cos    response owner and results (0 when not requested)
//   busy                        high whenever not idle
//   dp_in, dp_sel, dp_result    sin/cos unit interface (dp_sel 1 = sin, 0 = cos)

module sincos_sched #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_angle,
  input  logic [1:0]  req0_mode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_angle,
  input  logic [1:0]  req1_mode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_sin,
  output logic [31:0] rsp_cos,
  output logic        busy,
  output logic [31:0] dp_in,
  output logic        dp_sel,
  input  logic [31:0] dp_result
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE - 1);
  localparam logic [31:0]      QNan    = 32'h7FC00000;

  typedef enum logic [1:0] {StIdle, StSin, StCos, StResp} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      angle_q, angle_d;
  logic             want_cos_q, want_cos_d;
  logic             id_q, id_d;
  logic [31:0]      sin_q, sin_d;
  logic [31:0]      cos_q, cos_d;
  logic             last_q, last_d;   // requester granted most recently

  logic             grant1;
  logic [31:0]      acc_angle;
  logic [1:0]       acc_mode;
  logic             special;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    angle_d    = angle_q;
    want_cos_d = want_cos_q;
    id_d       = id_q;
    sin_d      = sin_q;
    cos_d      = cos_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    // req1 wins when alone, or on contention when req0 was granted last.
    grant1    = req1_valid & (~req0_valid | ~last_q);
    acc_angle = grant1 ? req1_angle : req0_angle;
    acc_mode  = grant1 ? req1_mode : req0_mode;
    if (acc_mode == 2'b00) acc_mode = 2'b11;
    special   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~grant1;
          req1_ready = grant1;
          id_d       = grant1;
          last_d     = grant1;
          want_cos_d = acc_mode[1];
          sin_d      = '0;
          cos_d      = '0;
          cnt_d      = '0;
`ifdef SINCOS_SCHED_SPECIAL_BYPASS_EN
          special    = (acc_angle[30:23] == 8'hFF);
`endif
          if (special) begin
            sin_d   = acc_mode[0] ? QNan : 32'h0;
            cos_d   = acc_mode[1] ? QNan : 32'h0;
            state_d = StResp;
          end else begin
            angle_d = acc_angle;
            state_d = acc_mode[0] ? StSin : StCos;
          end
        end
      end
      StSin: begin
        if (cnt_q == CntLast) begin
          sin_d   = dp_result;
          cnt_d   = '0;
          state_d = want_cos_q ? StCos : StResp;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StCos: begin
        if (cnt_q == CntLast) begin
          cos_d   = dp_result;
          cnt_d   = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      angle_q    <= '0;
      want_cos_q <= 1'b0;
      id_q       <= 1'b0;
      sin_q      <= '0;
      cos_q      <= '0;
      last_q     <= 1'b1;   // so req0 wins the first contention
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      angle_q    <= angle_d;
      want_cos_q <= want_cos_d;
      id_q       <= id_d;
      sin_q      <= sin_d;
      cos_q      <= cos_d;
      last_q     <= last_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);
  assign dp_sel    = (state_q == StSin);
  assign dp_in     = angle_q;
  assign rsp_id    = id_q;
  assign rsp_sin   = sin_q;
  assign rsp_cos   = cos_q;

endmodule

// File: tb/tb_sincos_sched.sv
// Directed testbench for sincos_sched (SETTLE=2). A small lookup model stands in for
// the sin/cos unit: known angles return true results, other angles return the angle
// XORed with a per-function constant so captured values are traceable.

module tb_sincos_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_angle = '0, req1_angle = '0;
  logic [1:0]  req0_mode = '0, req1_mode = '0;
  logic        rsp_valid, rsp_id, busy, dp_sel;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_sin, rsp_cos, dp_in, dp_result;

  int passed = 0;
  int total  = 0;

  sincos_sched #(.SETTLE(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_angle(req0_angle), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_angle(req1_angle), .req1_mode(req1_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sin(rsp_sin), .rsp_cos(rsp_cos), .busy(busy),
    .dp_in(dp_in), .dp_sel(dp_sel), .dp_result(dp_result)
  );

  always #5 clk = ~clk;

  // Sin/cos unit stand-in.
  always_comb begin
    dp_result = '0;
    case (dp_in)
      32'h00000000: dp_result = dp_sel ? 32'h00000000 : 32'h3F800000;
      32'h3FC90FDB: dp_result = dp_sel ? 32'h3F800000 : 32'hB33BBD2E;
      default:      dp_result = dp_sel ? (dp_in ^ 32'h5A5A5A5A) : (dp_in ^ 32'hA5A5A5A5);
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request, hand it off, then count cycles after the accept until rsp_valid.
  task automatic issue(input bit id, input logic [31:0] ang, input logic [1:0] mode,
                       output int lat, output bit rdy_ok, output bit sel0);
    if (id) begin
      req1_valid = 1'b1; req1_angle = ang; req1_mode = mode;
    end else begin
      req0_valid = 1'b1; req0_angle = ang; req0_mode = mode;
    end
    #1;
    rdy_ok = id ? (req1_ready && !req0_ready) : (req0_ready && !req1_ready);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat  = -1;
    sel0 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (rsp_valid) begin
        lat = n;
        break;
      end
      if (!dp_sel) sel0 = 1'b1;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (dp_sel !== 1'b0) $display("FAIL reset_dp_sel: got %b want 0", dp_sel); else passed++;
    total++; if (dp_in !== 32'h0) $display("FAIL reset_dp_in: got %h want 0", dp_in); else passed++;
    total++; if (rsp_sin !== 32'h0) $display("FAIL reset_rsp_sin: got %h want 0", rsp_sin); else passed++;
    total++; if (rsp_cos !== 32'h0) $display("FAIL reset_rsp_cos: got %h want 0", rsp_cos); else passed++;
    total++; if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id: got %b want 0", rsp_id); else passed++;
  endtask

  task automatic test_both_funcs();
    int lat; bit rdy, sel0;
    issue(1'b0, 32'h00000000, 2'b11, lat, rdy, sel0);
    total++; if (rdy !== 1'b1) $display("FAIL both_ready: got %b want 1", rdy); else passed++;
    total++; if (lat != 5) $display("FAIL both_latency: got %0d want 5", lat); else passed++;
    total++; if (rsp_sin !== 32'h00000000) $display("FAIL both_sin: got %h want 00000000", rsp_sin); else passed++;
    total++; if (rsp_cos !== 32'h3F800000) $display("FAIL both_cos: got %h want 3f800000", rsp_cos); else passed++;
    total++; if (rsp_id !== 1'b0) $display("FAIL both_id: got %b want 0", rsp_id); else passed++;
    step();
  endtask

  task automatic test_sin_only();
    int lat; bit rdy, sel0;
    issue(1'b1, 32'h3FC90FDB, 2'b01, lat, rdy, sel0);
    total++; if (rdy !== 1'b1) $display("FAIL sin_ready: got %b want 1", rdy); else passed++;
    total++; if (lat != 3) $display("FAIL sin_latency: got %0d want 3", lat); else passed++;
    total++; if (rsp_sin !== 32'h3F800000) $display("FAIL sin_value: got %h want 3f800000", rsp_sin); else passed++;
    total++; if (rsp_cos !== 32'h0) $display("FAIL sin_cos_zero: got %h want 0", rsp_cos); else passed++;
    total++; if (rsp_id !== 1'b1) $display("FAIL sin_id: got %b want 1", rsp_id); else passed++;
    total++; if (sel0 !== 1'b0) $display("FAIL sin_dp_sel: saw dp_sel=0 %b want never", sel0); else passed++;
    step();
  endtask

  task automatic test_round_robin();
    int grants = 0, rsps = 0, bad = 0;
    logic [3:0] g = '0, r = '0;
    req0_angle = 32'h40000000; req0_mode = 2'b10;
    req1_angle = 32'h40400000; req1_mode = 2'b10;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 80 && rsps < 4; c++) begin
      #1;
      if (req0_ready && req1_ready) bad++;
      if ((req0_ready || req1_ready) && busy) bad++;
      if (req0_ready || req1_ready) begin
        if (grants < 4) g[grants] = req1_ready;
        grants++;
      end
      if (rsp_valid) begin
        r[rsps] = rsp_id;
        rsps++;
      end
      step();
      if (grants >= 4) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++; if (grants != 4) $display("FAIL rr_grant_count: got %0d want 4", grants); else passed++;
    total++; if (g !== 4'b1010) $display("FAIL rr_grant_order: got %b want 1010 (lsb first)", g); else passed++;
    total++; if (r !== 4'b1010) $display("FAIL rr_rsp_order: got %b want 1010 (lsb first)", r); else passed++;
    total++; if (bad != 0) $display("FAIL rr_ready_pulse: got %0d bad cycles want 0", bad); else passed++;
    #1;
  endtask

  task automatic test_backpressure();
    int lat, bad = 0; bit rdy, sel0;
    logic [31:0] s, c; logic i;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h40490FDB, 2'b11, lat, rdy, sel0);
    total++; if (lat != 5) $display("FAIL bp_latency: got %0d want 5", lat); else passed++;
    s = rsp_sin; c = rsp_cos; i = rsp_id;
    total++; if (s !== 32'h1A135581) $display("FAIL bp_sin: got %h want 1a135581", s); else passed++;
    total++; if (c !== 32'hE5ECAA7E) $display("FAIL bp_cos: got %h want e5ecaa7e", c); else passed++;
    req1_valid = 1'b1; req1_angle = 32'h3FC90FDB; req1_mode = 2'b01;
    repeat (10) begin
      #1;
      if (rsp_sin !== s || rsp_cos !== c || rsp_id !== i || !rsp_valid || !busy) bad++;
      if (req0_ready || req1_ready) bad++;
      step();
    end
    total++; if (bad != 0) $display("FAIL bp_hold: got %0d bad cycles want 0", bad); else passed++;
    rsp_ready = 1'b1;
    step();
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL bp_release_idle: got busy=%b valid=%b want 0/0", busy, rsp_valid); else passed++;
    total++; if (req1_ready !== 1'b1) $display("FAIL bp_next_accept: got %b want 1", req1_ready); else passed++;
    step();
    req1_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (rsp_valid) begin lat = n; break; end
      step();
    end
    total++; if (lat != 3 || rsp_sin !== 32'h3F800000 || rsp_id !== 1'b1)
      $display("FAIL bp_followup: got lat=%0d sin=%h id=%b want 3/3f800000/1", lat, rsp_sin, rsp_id); else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    req0_valid = 1'b1; req0_angle = 32'h3F000000; req0_mode = 2'b11;
    #1;
    step();
    req0_valid = 1'b0;
    step(); step();
    total++; if (busy !== 1'b1 || dp_sel !== 1'b0 || rsp_sin !== 32'h655A5A5A)
      $display("FAIL mid_in_cos: got busy=%b sel=%b sin=%h want 1/0/655a5a5a", busy, dp_sel, rsp_sin); else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); else passed++;
    total++; if (rsp_sin !== 32'h0) $display("FAIL mid_rsp_sin: got %h want 0", rsp_sin); else passed++;
    req0_valid = 1'b1; req0_angle = 32'h00000000; req0_mode = 2'b11;
    req1_valid = 1'b1; req1_angle = 32'h3FC90FDB; req1_mode = 2'b11;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL mid_priority: got r0=%b r1=%b want 1/0", req0_ready, req1_ready); else passed++;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (rsp_valid) begin lat = n; break; end
      step();
    end
    total++; if (lat != 5) $display("FAIL mid_latency: got %0d want 5", lat); else passed++;
    total++; if (rsp_id !== 1'b0 || rsp_sin !== 32'h0 || rsp_cos !== 32'h3F800000)
      $display("FAIL mid_result: got id=%b sin=%h cos=%h want 0/00000000/3f800000", rsp_id, rsp_sin, rsp_cos); else passed++;
    step();
  endtask

  task automatic test_special();
    int lat; bit rdy, sel0;
    int exp_lat_both, exp_lat_sin;
    logic [31:0] exp_sin, exp_cos;
`ifdef SINCOS_SCHED_SPECIAL_BYPASS_EN
    exp_lat_both = 1; exp_lat_sin = 1;
    exp_sin = 32'h7FC00000; exp_cos = 32'h7FC00000;
`else
    exp_lat_both = 5; exp_lat_sin = 3;
    exp_sin = 32'h25DA5A5A; exp_cos = 32'hDA25A5A5;
`endif
    issue(1'b0, 32'h7F800000, 2'b11, lat, rdy, sel0);
    total++; if (lat != exp_lat_both) $display("FAIL special_latency: got %0d want %0d", lat, exp_lat_both); else passed++;
    total++; if (rsp_sin !== exp_sin) $display("FAIL special_sin: got %h want %h", rsp_sin, exp_sin); else passed++;
    total++; if (rsp_cos !== exp_cos) $display("FAIL special_cos: got %h want %h", rsp_cos, exp_cos); else passed++;
    step();
    issue(1'b1, 32'h7F800000, 2'b01, lat, rdy, sel0);
    total++; if (lat != exp_lat_sin) $display("FAIL special_sin_latency: got %0d want %0d", lat, exp_lat_sin); else passed++;
    total++; if (rsp_sin !== exp_sin || rsp_cos !== 32'h0)
      $display("FAIL special_sin_only: got sin=%h cos=%h want %h/00000000", rsp_sin, rsp_cos, exp_sin); else passed++;
    step();
  endtask

  task automatic test_mode_zero();
    int lat; bit rdy, sel0;
    issue(1'b0, 32'h00000000, 2'b00, lat, rdy, sel0);
    total++; if (lat != 5) $display("FAIL mode0_latency: got %0d want 5", lat); else passed++;
    total++; if (rsp_sin !== 32'h0 || rsp_cos !== 32'h3F800000)
      $display("FAIL mode0_result: got sin=%h cos=%h want 00000000/3f800000", rsp_sin, rsp_cos); else passed++;
    step();
  endtask

  initial begin
    test_reset();
    test_both_funcs();
    test_sin_only();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_special();
    test_mode_zero();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
